rc5_stream_adapter: RTL and testbench
=====================================

// Module: rc5_stream_adapter
// PURPOSE
//  Byte-stream front end for the RC5 core (dut). Loads the B-byte secret key into
//  the core's key RAM, packs plaintext/ciphertext bytes into A/B words, and holds
//  the core's start request until it reports done. It then serialises the result
//  words back out as bytes. Sits directly upstream/downstream of dut.
// PARAMETERS
//  W        32    RC5 word width in bits; a block is 2*W/8 bytes
//  B        16    key length in bytes; equals the dut key RAM depth
//  TIMEOUT  4096  max cycles to wait for done (used only with RC5_TIMEOUT_EN)
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          asynchronous reset, active-low
//  iByte          in   8          input byte (key or data)
//  iByteValid     in   1          iByte valid
//  oByteReady     out  1          adapter accepts iByte this cycle
//  iKeyLoad       in   1          1: incoming bytes are key bytes; sampled in IDLE
//  iMode          in   1          0 cipher, 1 decipher; sampled with block byte 0
//  oKey_sub_i     out  8          key byte to dut key RAM
//  oKey_address   out  $clog2(B)  key RAM address
//  oWen           out  1          key RAM write strobe
//  oA, oB         out  W          block words to dut (iA/iB or iA_cipher/iB_cipher)
//  oStartCipher   out  1          level start to dut iStartCipher
//  oStartDecipher out  1          level start to dut iStartDecipher
//  iDoneCipher    in   1          dut oDoneCipher
//  iDoneDecipher  in   1          dut oDoneDecipher
//  iResA, iResB   in   W          dut result words (cipher or decipher, muxed by mode)
//  oByte          out  8          output byte
//  oByteValid     out  1          oByte valid
//  iByteReady     in   1          downstream accepts oByte
//  oKeyLoaded     out  1          a full key is present in key RAM
//  oBusy          out  1          state != IDLE
//  oError         out  1          sticky timeout flag (0 when RC5_TIMEOUT_EN is undefined)
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, state IDLE, counters 0, oKeyLoaded 0.
//  Byte transfer on iByteValid&&oByteReady; output transfer on oByteValid&&iByteReady.
//  FSM: IDLE -> KEY (iKeyLoad=1) | COLLECT (iKeyLoad=0 && oKeyLoaded)
//       KEY -> IDLE after byte B-1; COLLECT -> RUN after byte 2*W/8-1;
//       RUN -> EMIT on done; EMIT -> IDLE after last byte accepted.
//  IDLE: oByteReady = iKeyLoad || oKeyLoaded. The first accepted byte enters KEY or
//   COLLECT in the same cycle and is consumed. With no key and iKeyLoad=0, ready=0.
//  KEY: each accepted byte gives a 1-cycle oWen with oKey_sub_i=byte and
//   oKey_address=count (0..B-1, registered, next cycle). The first key byte clears
//   oKeyLoaded. The last byte sets oKeyLoaded. Changes to iKeyLoad mid-load are ignored.
//  COLLECT: little-endian packing. Byte k (k<W/8) -> oA[8k+7:8k].
//   Byte W/8+k -> oB[8k+7:8k]. iMode is latched on byte 0.
//  RUN: oByteReady=0. The start line for the latched mode rises in the cycle after the
//   last data byte and holds high until the matching done is sampled high. Only the
//   matching done is honoured. In the done cycle, capture iResA/iResB, drop start
//   (next cycle) and enter EMIT. oA/oB stay stable for the whole of RUN.
//  EMIT: oByteValid=1. Emits oA-result bytes LSB first, then oB-result bytes (2*W/8
//   total). oByte holds under backpressure. Return to IDLE after the last transfer.
//   A new block may then start the next cycle.
//  Wrap: byte counters are $clog2(max(B,2*W/8)) bits and reset to 0 on every state entry.
//  Simultaneous: done and a timeout expiry in the same cycle -> done wins.
//  Reset mid-operation: immediate return to IDLE, starts drop asynchronously, and
//   oKeyLoaded clears, so the key must be reloaded.
// CONFIGURATION
//  RC5_TIMEOUT_EN defined: a cycle counter runs in RUN. Reaching TIMEOUT without done
//   drops start, sets oError (sticky until reset) and goes to IDLE with no output bytes.
//  RC5_TIMEOUT_EN undefined: RUN waits forever, no counter logic, oError tied 0.
// TESTING
//  1 Key 16x00, mode 0, bytes 8x00 -> oStartCipher held until done, then output
//    21 A5 DB EE 15 4B 8F 6D (oA=0,oB=0 sent; result A=EEDBA521,B=6D8F4B15).
//  2 Same key, mode 1, send 21 A5 DB EE 15 4B 8F 6D -> output 8x00, only oStartDecipher.
//  3 Key load 00..0F -> oWen 16 pulses, addr 0..15 match data; oKeyLoaded rises after 16th.
//  4 No key, iKeyLoad=0, iByteValid=1 -> oByteReady stays 0, no start asserted.
//  5 Output with iByteReady toggling 1/0 -> oByte stable while stalled, 8 bytes in order.
//  6 RC5_TIMEOUT_EN, TIMEOUT=16, done never asserted -> start drops at cycle 16,
//    oError=1, no output; reset mid-COLLECT -> all outputs 0, oKeyLoaded 0.

Source files
------------

// File: rtl/rc5_stream_adapter.sv
// Byte-stream front end for the RC5 core: key loading, block packing, start/done handshake, result serialisation.
// Optional RUN watchdog enabled by defining RC5_TIMEOUT_EN.
module rc5_stream_adapter #(
  parameter int unsigned W       = 32,
  parameter int unsigned B       = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           iByte,
  input  logic                 iByteValid,
  output logic                 oByteReady,
  input  logic                 iKeyLoad,
  input  logic                 iMode,
  output logic [7:0]           oKey_sub_i,
  output logic [$clog2(B)-1:0] oKey_address,
  output logic                 oWen,
  output logic [W-1:0]         oA,
  output logic [W-1:0]         oB,
  output logic                 oStartCipher,
  output logic                 oStartDecipher,
  input  logic                 iDoneCipher,
  input  logic                 iDoneDecipher,
  input  logic [W-1:0]         iResA,
  input  logic [W-1:0]         iResB,
  output logic [7:0]           oByte,
  output logic                 oByteValid,
  input  logic                 iByteReady,
  output logic                 oKeyLoaded,
  output logic                 oBusy,
  output logic                 oError
);

  localparam int unsigned NB   = 2 * W / 8;
  localparam int unsigned HB   = W / 8;
  localparam int unsigned NMAX = (B > NB) ? B : NB;
  localparam int unsigned CW   = $clog2(NMAX);
  localparam int unsigned AW   = $clog2(B);

  // Elaboration guard against parameter sets the datapath cannot represent.
  if ((W % 8 != 0) || (B < 2) || (TIMEOUT < 2)) begin : g_param_check
    $error("rc5_stream_adapter: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_COLLECT,
    S_RUN,
    S_EMIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [2*W-1:0]  res_q, res_d;
  logic [W-1:0]    a_d, b_d;
  logic [7:0]      byte_d, kdata_d;
  logic [AW-1:0]   kaddr_d;
  logic            bvalid_d, wen_d, scip_d, sdec_d, kloaded_d, busy_d, err_d;
  logic            in_fire, out_fire, done;

`ifdef RC5_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   tcnt_q, tcnt_d;
`endif

  // Ready is combinational so a byte can be taken in the same cycle IDLE decides KEY vs COLLECT.
  always_comb begin
    oByteReady = 1'b0;
    case (state_q)
      S_IDLE:           oByteReady = iKeyLoad || oKeyLoaded;
      S_KEY, S_COLLECT: oByteReady = 1'b1;
      default:          oByteReady = 1'b0;
    endcase
  end

  assign in_fire  = iByteValid && oByteReady;
  assign out_fire = oByteValid && iByteReady;
  assign done     = mode_q ? iDoneDecipher : iDoneCipher;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    res_d     = res_q;
    a_d       = oA;
    b_d       = oB;
    byte_d    = oByte;
    bvalid_d  = oByteValid;
    wen_d     = 1'b0;
    kdata_d   = oKey_sub_i;
    kaddr_d   = oKey_address;
    scip_d    = oStartCipher;
    sdec_d    = oStartDecipher;
    kloaded_d = oKeyLoaded;
    err_d     = oError;
`ifdef RC5_TIMEOUT_EN
    tcnt_d    = tcnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          cnt_d = CW'(1);
          if (iKeyLoad) begin
            wen_d     = 1'b1;
            kdata_d   = iByte;
            kaddr_d   = '0;
            kloaded_d = 1'b0;
            state_d   = S_KEY;
          end else begin
            mode_d    = iMode;
            a_d[7:0]  = iByte;
            state_d   = S_COLLECT;
          end
        end
      end

      S_KEY: begin
        if (in_fire) begin
          wen_d   = 1'b1;
          kdata_d = iByte;
          kaddr_d = AW'(cnt_q);
          if (cnt_q == CW'(B - 1)) begin
            kloaded_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_COLLECT: begin
        if (in_fire) begin
          if (cnt_q < CW'(HB)) a_d[8*cnt_q +: 8] = iByte;
          else                 b_d[8*(cnt_q - CW'(HB)) +: 8] = iByte;
          if (cnt_q == CW'(NB - 1)) begin
            cnt_d   = '0;
            scip_d  = !mode_q;
            sdec_d  = mode_q;
            state_d = S_RUN;
`ifdef RC5_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_RUN: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (done) begin
          scip_d   = 1'b0;
          sdec_d   = 1'b0;
          res_d    = {iResB, iResA};
          byte_d   = iResA[7:0];
          bvalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_EMIT;
        end
`ifdef RC5_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          scip_d  = 1'b0;
          sdec_d  = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end

      S_EMIT: begin
        if (out_fire) begin
          if (cnt_q == CW'(NB - 1)) begin
            bvalid_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_IDLE;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            res_d  = res_q >> 8;
            byte_d = res_q[15:8];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      mode_q         <= 1'b0;
      res_q          <= '0;
      oA             <= '0;
      oB             <= '0;
      oByte          <= '0;
      oByteValid     <= 1'b0;
      oWen           <= 1'b0;
      oKey_sub_i     <= '0;
      oKey_address   <= '0;
      oStartCipher   <= 1'b0;
      oStartDecipher <= 1'b0;
      oKeyLoaded     <= 1'b0;
      oBusy          <= 1'b0;
      oError         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      res_q          <= res_d;
      oA             <= a_d;
      oB             <= b_d;
      oByte          <= byte_d;
      oByteValid     <= bvalid_d;
      oWen           <= wen_d;
      oKey_sub_i     <= kdata_d;
      oKey_address   <= kaddr_d;
      oStartCipher   <= scip_d;
      oStartDecipher <= sdec_d;
      oKeyLoaded     <= kloaded_d;
      oBusy          <= busy_d;
`ifdef RC5_TIMEOUT_EN
      oError         <= err_d;
`else
      oError         <= 1'b0;
`endif
    end
  end

`ifdef RC5_TIMEOUT_EN
  // Watchdog counter, cleared on every entry to RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tcnt_q <= '0;
    else      tcnt_q <= tcnt_d;
  end
`endif

endmodule

// File: tb/tb_rc5_stream_adapter.sv
// Directed self-checking bench for rc5_stream_adapter; the RC5 core is stood in for by hand-driven done/result vectors.
module tb_rc5_stream_adapter;

  localparam int unsigned W  = 32;
  localparam int unsigned B  = 16;
  localparam int unsigned NB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  iByte = 8'h00;
  logic        iByteValid = 1'b0;
  logic        oByteReady;
  logic        iKeyLoad = 1'b0;
  logic        iMode = 1'b0;
  logic [7:0]  oKey_sub_i;
  logic [3:0]  oKey_address;
  logic        oWen;
  logic [W-1:0] oA, oB;
  logic        oStartCipher, oStartDecipher;
  logic        iDoneCipher = 1'b0;
  logic        iDoneDecipher = 1'b0;
  logic [W-1:0] iResA = '0;
  logic [W-1:0] iResB = '0;
  logic [7:0]  oByte;
  logic        oByteValid;
  logic        iByteReady = 1'b0;
  logic        oKeyLoaded, oBusy, oError;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rc5_stream_adapter #(.W(W), .B(B), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .iByte(iByte), .iByteValid(iByteValid), .oByteReady(oByteReady),
    .iKeyLoad(iKeyLoad), .iMode(iMode),
    .oKey_sub_i(oKey_sub_i), .oKey_address(oKey_address), .oWen(oWen),
    .oA(oA), .oB(oB),
    .oStartCipher(oStartCipher), .oStartDecipher(oStartDecipher),
    .iDoneCipher(iDoneCipher), .iDoneDecipher(iDoneDecipher),
    .iResA(iResA), .iResB(iResB),
    .oByte(oByte), .oByteValid(oByteValid), .iByteReady(iByteReady),
    .oKeyLoaded(oKeyLoaded), .oBusy(oBusy), .oError(oError)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [7:0] base, input logic inc);
    logic [7:0] kb;
    iKeyLoad   = 1'b1;
    iByteValid = 1'b1;
    for (int i = 0; i < int'(B); i++) begin
      kb    = inc ? (base + 8'(i)) : base;
      iByte = kb;
      if (i >= 5 && i <= 7) iKeyLoad = 1'b0;
      else                  iKeyLoad = 1'b1;
      #1 check("key_ready", 64'(oByteReady), 64'h1);
      tick();
      check("key_wen",  64'(oWen), 64'h1);
      check("key_addr", 64'(oKey_address), 64'(i));
      check("key_data", 64'(oKey_sub_i), 64'(kb));
      if (i == 0)          check("key_loaded_clr", 64'(oKeyLoaded), 64'h0);
      if (i == int'(B) - 2) check("key_loaded_mid", 64'(oKeyLoaded), 64'h0);
      if (i == int'(B) - 1) check("key_loaded_set", 64'(oKeyLoaded), 64'h1);
    end
    iByteValid = 1'b0;
    iKeyLoad   = 1'b0;
    tick();
    check("key_wen_drop", 64'(oWen), 64'h0);
    check("key_idle",     64'(oBusy), 64'h0);
  endtask

  // blk holds byte k in bits [8k+7:8k]; expA/expB are the hand-packed words.
  task automatic send_block(input logic mode, input logic [63:0] blk,
                            input logic [31:0] expA, input logic [31:0] expB);
    iMode      = mode;
    iByteValid = 1'b1;
    for (int k = 0; k < int'(NB); k++) begin
      iByte = blk[8*k +: 8];
      #1 check("blk_ready", 64'(oByteReady), 64'h1);
      tick();
      if (k < int'(NB) - 1)
        check("blk_no_start", 64'({oStartCipher, oStartDecipher}), 64'h0);
    end
    iByteValid = 1'b0;
    check("start_c",   64'(oStartCipher),   64'(!mode));
    check("start_d",   64'(oStartDecipher), 64'(mode));
    check("pack_a",    64'(oA), 64'(expA));
    check("pack_b",    64'(oB), 64'(expB));
    check("run_ready", 64'(oByteReady), 64'h0);
    check("run_busy",  64'(oBusy), 64'h1);
  endtask

  task automatic run_done(input logic mode, input int wait_cyc,
                          input logic [31:0] ra, input logic [31:0] rb,
                          input logic [31:0] expA, input logic [31:0] expB);
    for (int c = 0; c < wait_cyc; c++) begin
      tick();
      check("hold_c",   64'(oStartCipher),   64'(!mode));
      check("hold_d",   64'(oStartDecipher), 64'(mode));
      check("hold_out", 64'(oByteValid), 64'h0);
    end
    iResA = ra;
    iResB = rb;
    if (mode) iDoneCipher = 1'b1;
    else      iDoneDecipher = 1'b1;
    tick();
    check("wrong_done_c",  64'(oStartCipher),   64'(!mode));
    check("wrong_done_d",  64'(oStartDecipher), 64'(mode));
    check("wrong_done_ov", 64'(oByteValid), 64'h0);
    check("run_a_stable",  64'(oA), 64'(expA));
    check("run_b_stable",  64'(oB), 64'(expB));
    iDoneCipher   = 1'b0;
    iDoneDecipher = 1'b0;
    if (mode) iDoneDecipher = 1'b1;
    else      iDoneCipher = 1'b1;
    tick();
    iDoneCipher   = 1'b0;
    iDoneDecipher = 1'b0;
    iResA = 32'hDEADBEEF;
    iResB = 32'hCAFEF00D;
    check("done_starts", 64'({oStartCipher, oStartDecipher}), 64'h0);
    check("done_valid",  64'(oByteValid), 64'h1);
  endtask

  task automatic expect_out(input logic [63:0] exp, input logic stall);
    for (int k = 0; k < int'(NB); k++) begin
      if (stall) begin
        iByteReady = 1'b0;
        tick();
        check("stall_valid", 64'(oByteValid), 64'h1);
        check("stall_byte",  64'(oByte), 64'(exp[8*k +: 8]));
      end
      iByteReady = 1'b1;
      check("out_valid", 64'(oByteValid), 64'h1);
      check("out_byte",  64'(oByte), 64'(exp[8*k +: 8]));
      tick();
    end
    iByteReady = 1'b0;
    check("emit_end_valid", 64'(oByteValid), 64'h0);
    check("emit_end_idle",  64'(oBusy), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2;
    check("rst_ready",  64'(oByteReady), 64'h0);
    check("rst_starts", 64'({oStartCipher, oStartDecipher}), 64'h0);
    check("rst_flags",  64'({oKeyLoaded, oBusy, oError, oWen, oByteValid}), 64'h0);
    check("rst_words",  64'({oA, oB}), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // No key loaded: data bytes are refused
    iByte      = 8'h55;
    iByteValid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 check("nokey_ready", 64'(oByteReady), 64'h0);
      tick();
      check("nokey_state", 64'({oStartCipher, oStartDecipher, oBusy, oWen}), 64'h0);
    end
    iByteValid = 1'b0;

    // Key 00..0F, then reload with all zeros
    load_key(8'h00, 1'b1);
    load_key(8'h00, 1'b0);

    // Encrypt zero block with output backpressure
    send_block(1'b0, 64'h0, 32'h0, 32'h0);
    run_done(1'b0, 3, 32'hEEDBA521, 32'h6D8F4B15, 32'h0, 32'h0);
    expect_out(64'h6D8F4B15_EEDBA521, 1'b1);

    // Decrypt back to zero, full-rate output
    send_block(1'b1, 64'h6D8F4B15_EEDBA521, 32'hEEDBA521, 32'h6D8F4B15);
    run_done(1'b1, 2, 32'h0, 32'h0, 32'hEEDBA521, 32'h6D8F4B15);
    expect_out(64'h0, 1'b0);

    // Long wait for done: watchdog behaviour depends on build
    send_block(1'b0, 64'h0807060504030201, 32'h04030201, 32'h08070605);
    repeat (15) tick();
    check("wd_hold15", 64'(oStartCipher), 64'h1);
    tick();
`ifdef RC5_TIMEOUT_EN
    check("wd_start_drop", 64'(oStartCipher), 64'h0);
    check("wd_error",      64'(oError), 64'h1);
    check("wd_no_out",     64'(oByteValid), 64'h0);
    check("wd_idle",       64'(oBusy), 64'h0);
    repeat (3) tick();
    check("wd_error_sticky", 64'(oError), 64'h1);
    check("wd_still_no_out", 64'(oByteValid), 64'h0);
`else
    check("nowd_start", 64'(oStartCipher), 64'h1);
    check("nowd_error", 64'(oError), 64'h0);
    check("nowd_busy",  64'(oBusy), 64'h1);
    iResA       = 32'h11223344;
    iResB       = 32'h55667788;
    iDoneCipher = 1'b1;
    tick();
    iDoneCipher = 1'b0;
    expect_out(64'h55667788_11223344, 1'b0);
`endif

    // Reset in the middle of COLLECT
    iMode      = 1'b0;
    iByteValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iByte = 8'hA0 + 8'(k);
      tick();
    end
    iByteValid = 1'b0;
    check("pre_rst_busy", 64'(oBusy), 64'h1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_words", 64'({oA, oB}), 64'h0);
    check("mid_rst_flags", 64'({oKeyLoaded, oBusy, oError, oWen, oByteValid}), 64'h0);
    check("mid_rst_start", 64'({oStartCipher, oStartDecipher}), 64'h0);
    @(negedge clk);
    rst        = 1'b1;
    iByte      = 8'h77;
    iByteValid = 1'b1;
    #1 check("post_rst_ready", 64'(oByteReady), 64'h0);
    tick();
    check("post_rst_idle", 64'(oBusy), 64'h0);
    iByteValid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
